// File: rtl/kinematics_scheduler.sv
// Sequences three kinematics channels (VX, VY, WZ) through one shared serial multiplier
// and commits all three products atomically, with stale-done guard, timeout and overrun flags.
module kinematics_scheduler #(
  parameter int                 N_WIDTH        = 17,
  parameter int                 Q_WIDTH        = 8,
  parameter logic [N_WIDTH-1:0] COEF_VX        = 17'h00002,
  parameter logic [N_WIDTH-1:0] COEF_VY        = 17'h00002,
  parameter logic [N_WIDTH-1:0] COEF_WZ        = 17'h00002,
  parameter int                 TIMEOUT_CYCLES = 64
) (
  input  logic               KINEMATICS_SCHEDULER_CLOCK_50,
  input  logic               KINEMATICS_SCHEDULER_Reset_InHigh,
  input  logic               KINEMATICS_SCHEDULER_Sample_InHigh,
  input  logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_SumVX_InBus,
  input  logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_SumVY_InBus,
  input  logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_SumWZ_InBus,
  input  logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_MultResult_InBus,
  input  logic               KINEMATICS_SCHEDULER_MultComplete_InHigh,
  input  logic               KINEMATICS_SCHEDULER_MultOverflow_InHigh,
  output logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_MultA_OutBus,
  output logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_MultB_OutBus,
  output logic               KINEMATICS_SCHEDULER_MultStart_Out,
  output logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_VX_OutBus,
  output logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_VY_OutBus,
  output logic [N_WIDTH-1:0] KINEMATICS_SCHEDULER_WZ_OutBus,
  output logic [2:0]         KINEMATICS_SCHEDULER_Ovf_OutBus,
  output logic               KINEMATICS_SCHEDULER_Valid_OutHigh,
  output logic               KINEMATICS_SCHEDULER_Busy_OutHigh,
  output logic [1:0]         KINEMATICS_SCHEDULER_Error_OutHigh
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         r_ch;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [N_WIDTH-1:0] r_op_vx, r_op_vy, r_op_wz;
  logic [N_WIDTH-1:0] r_sh_vx, r_sh_vy, r_sh_wz;
  logic [2:0]         r_sh_ovf;
  logic [N_WIDTH-1:0] r_vx, r_vy, r_wz;
  logic [2:0]         r_ovf;
  logic               r_valid;
  logic [1:0]         r_err;

  logic [N_WIDTH-1:0] w_sel_op;
  logic [N_WIDTH-1:0] w_sel_coef;
  logic               w_mult_phase;
  logic               w_capture;
  logic               w_timeout;

  always_comb begin
    w_sel_op   = r_op_vx;
    w_sel_coef = COEF_VX;
    case (r_ch)
      2'd1: begin
        w_sel_op   = r_op_vy;
        w_sel_coef = COEF_VY;
      end
      2'd2: begin
        w_sel_op   = r_op_wz;
        w_sel_coef = COEF_WZ;
      end
      default: ;
    endcase
  end

  assign w_mult_phase = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  // A done level seen in the first WAIT cycle may belong to the previous channel.
  assign w_capture = (r_state == ST_WAIT) && (r_wait_cnt != '0) &&
                     KINEMATICS_SCHEDULER_MultComplete_InHigh;
  assign w_timeout = (r_state == ST_WAIT) && !w_capture && (r_wait_cnt == LAST_WAIT);

  always_ff @(posedge KINEMATICS_SCHEDULER_CLOCK_50) begin
    if (KINEMATICS_SCHEDULER_Reset_InHigh) begin
      r_state    <= ST_IDLE;
      r_ch       <= 2'd0;
      r_wait_cnt <= '0;
      r_op_vx    <= '0;
      r_op_vy    <= '0;
      r_op_wz    <= '0;
      r_sh_vx    <= '0;
      r_sh_vy    <= '0;
      r_sh_wz    <= '0;
      r_sh_ovf   <= 3'b000;
      r_vx       <= '0;
      r_vy       <= '0;
      r_wz       <= '0;
      r_ovf      <= 3'b000;
      r_valid    <= 1'b0;
      r_err      <= 2'b00;
    end else begin
      r_valid <= 1'b0;
      if (KINEMATICS_SCHEDULER_Sample_InHigh && (r_state != ST_IDLE)) begin
        r_err[1] <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (KINEMATICS_SCHEDULER_Sample_InHigh) begin
            r_op_vx <= KINEMATICS_SCHEDULER_SumVX_InBus;
            r_op_vy <= KINEMATICS_SCHEDULER_SumVY_InBus;
            r_op_wz <= KINEMATICS_SCHEDULER_SumWZ_InBus;
            r_ch    <= 2'd0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_capture) begin
            case (r_ch)
              2'd1:    r_sh_vy <= KINEMATICS_SCHEDULER_MultResult_InBus;
              2'd2:    r_sh_wz <= KINEMATICS_SCHEDULER_MultResult_InBus;
              default: r_sh_vx <= KINEMATICS_SCHEDULER_MultResult_InBus;
            endcase
            r_sh_ovf[r_ch] <= KINEMATICS_SCHEDULER_MultOverflow_InHigh;
            if (r_ch == 2'd2) begin
              r_state <= ST_DONE;
            end else begin
              r_ch    <= r_ch + 2'd1;
              r_state <= ST_ISSUE;
            end
          end else if (w_timeout) begin
            r_err[0] <= 1'b1;
            r_sh_vx  <= '0;
            r_sh_vy  <= '0;
            r_sh_wz  <= '0;
            r_sh_ovf <= 3'b000;
            r_ch     <= 2'd0;
            r_state  <= ST_IDLE;
          end
        end
        ST_DONE: begin
          // All three channels land on the same edge so no partial set is ever visible.
          r_vx    <= r_sh_vx;
          r_vy    <= r_sh_vy;
          r_wz    <= r_sh_wz;
          r_ovf   <= r_sh_ovf;
          r_valid <= 1'b1;
          r_ch    <= 2'd0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign KINEMATICS_SCHEDULER_MultA_OutBus    = w_mult_phase ? w_sel_op : '0;
  assign KINEMATICS_SCHEDULER_MultB_OutBus    = w_mult_phase ? w_sel_coef : '0;
  assign KINEMATICS_SCHEDULER_MultStart_Out   = (r_state == ST_ISSUE);
  assign KINEMATICS_SCHEDULER_VX_OutBus       = r_vx;
  assign KINEMATICS_SCHEDULER_VY_OutBus       = r_vy;
  assign KINEMATICS_SCHEDULER_WZ_OutBus       = r_wz;
  assign KINEMATICS_SCHEDULER_Ovf_OutBus      = r_ovf;
  assign KINEMATICS_SCHEDULER_Valid_OutHigh   = r_valid;
  assign KINEMATICS_SCHEDULER_Busy_OutHigh    = (r_state != ST_IDLE);
  assign KINEMATICS_SCHEDULER_Error_OutHigh   = r_err;

endmodule

// File: doc/kinematics_scheduler.md
KINEMATICS_SCHEDULER -- requirements
Module: kinematics_scheduler

Interface
REQ-001 The block SHALL have parameter N_WIDTH, default 17, fixed-point word width, sign-magnitude U(N,Q).
REQ-002 The block SHALL have parameter Q_WIDTH, default 8, number of fractional bits.
REQ-003 The block SHALL have parameters COEF_VX, COEF_VY, COEF_WZ, each N_WIDTH bits, default 17'h00002, the per-channel multiplier coefficients.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of WAIT cycles per multiply.
REQ-005 The block SHALL have one clock and a synchronous active-high reset, ports as follows:
- KINEMATICS_SCHEDULER_CLOCK_50  in  1  clock, all logic rising-edge
- KINEMATICS_SCHEDULER_Reset_InHigh  in  1  synchronous active-high reset
- KINEMATICS_SCHEDULER_Sample_InHigh  in  1  request a new kinematics evaluation
- KINEMATICS_SCHEDULER_SumVX_InBus / SumVY_InBus / SumWZ_InBus  in  N_WIDTH  wheel-speed sums per channel
- KINEMATICS_SCHEDULER_MultResult_InBus  in  N_WIDTH  product from the shared serial multiplier
- KINEMATICS_SCHEDULER_MultComplete_InHigh  in  1  multiplier done level
- KINEMATICS_SCHEDULER_MultOverflow_InHigh  in  1  multiplier overflow
- KINEMATICS_SCHEDULER_MultA_OutBus  out  N_WIDTH  multiplicand to the multiplier
- KINEMATICS_SCHEDULER_MultB_OutBus  out  N_WIDTH  multiplier coefficient
- KINEMATICS_SCHEDULER_MultStart_Out  out  1  one-cycle start pulse
- KINEMATICS_SCHEDULER_VX_OutBus / VY_OutBus / WZ_OutBus  out  N_WIDTH  committed results
- KINEMATICS_SCHEDULER_Ovf_OutBus  out  3  per-channel overflow {WZ,VY,VX}, committed with the results
- KINEMATICS_SCHEDULER_Valid_OutHigh  out  1  one-cycle pulse on commit
- KINEMATICS_SCHEDULER_Busy_OutHigh  out  1  high in every state except IDLE
- KINEMATICS_SCHEDULER_Error_OutHigh  out  2  sticky {overrun, timeout}

Function
REQ-006 The FSM SHALL have the states IDLE, ISSUE, WAIT, DONE and the channel index ch in {0=VX, 1=VY, 2=WZ}.
REQ-007 In IDLE with Sample=1, the block SHALL snapshot all three sums into operand registers, set ch=0 and move to ISSUE on the next edge.
REQ-008 In ISSUE, the block SHALL assert MultStart=1 for exactly one cycle, clear the timeout counter and move to WAIT.
REQ-009 MultA SHALL equal the snapshot sum of channel ch and MultB SHALL equal COEF of channel ch, held stable in ISSUE and WAIT; both SHALL be 0 in IDLE and DONE.
REQ-010 In the first WAIT cycle, the block SHALL ignore MultComplete (stale-done guard).
REQ-011 From the second WAIT cycle, MultComplete=1 SHALL store MultResult and MultOverflow into the shadow slot for ch; then ch<2 SHALL increment ch and go to ISSUE, and ch=2 SHALL go to DONE.
REQ-012 In DONE, the block SHALL copy all three shadow slots to VX/VY/WZ_OutBus and Ovf_OutBus on the same edge, pulse Valid for one cycle and return to IDLE.
REQ-013 Outputs SHALL never show a partially updated result set.
REQ-014 The WAIT counter SHALL increment each WAIT cycle; when it reaches TIMEOUT_CYCLES without a complete, the block SHALL set Error[0], discard the shadows, leave the committed outputs unchanged, produce no Valid and return to IDLE.
REQ-015 Sample=1 in any state other than IDLE SHALL be ignored and SHALL set Error[1].
REQ-016 Sample held high SHALL start a new evaluation on each return to IDLE; that Sample in IDLE SHALL NOT set Error[1].
REQ-017 Error bits SHALL clear only on reset.
REQ-018 The block SHALL apply no arithmetic to the data: results pass through bit-exact, sign bit included.
REQ-019 Latency SHALL be Sample edge to Valid = 1 + 3*(1 + W) + 1 cycles, where W is the number of WAIT cycles per channel (W >= 2).

Reset
REQ-020 Reset SHALL put the FSM in IDLE with ch=0, counters 0 and shadows 0.
REQ-021 Reset SHALL drive all outputs to 0: results, Ovf, Valid, Busy, Error, MultStart, MultA, MultB.
REQ-022 Reset SHALL take priority over all other inputs in every state.
REQ-023 Reset mid-operation SHALL abort the evaluation with no Valid.

Verification
REQ-024 Basic: the multiplier model completes 18 cycles after start and returns A*B; sums VX=0x00400, VY=0x10200, WZ=0x00100 -> VX=0x00008, VY=0x10004, WZ=0x00002, Ovf=000, one Valid pulse at cycle 1+3*19+1=59.
REQ-025 Stale-done: MultComplete held high continuously -> each channel captures on its second WAIT cycle and Valid occurs at cycle 1+3*3+1=11.
REQ-026 Timeout: MultComplete never asserts -> Error=01 after 64 WAIT cycles, previous results unchanged, no Valid, Busy low afterwards.
REQ-027 Overrun: Sample pulsed again 5 cycles after the first -> Error=10 and exactly one Valid, with results from the first snapshot even though the sum inputs changed.
REQ-028 Reset mid-WAIT on channel 1 -> all outputs 0 on the next cycle; a following Sample completes normally.
REQ-029 Overflow: MultOverflow=1 on the WZ channel only -> Ovf=100 at commit.
